// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue FSM in front of the registered ALU.
// Divide/remainder by zero is trapped locally and never reaches the ALU.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_a,
  input  logic [15:0]                cmd_b,
  input  logic [2:0]                 cmd_sel,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [15:0]                alu_input1,
  output logic [15:0]                alu_input2,
  output logic [2:0]                 alu_select,
  input  logic [16:0]                alu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [16:0]                rsp_data,
  output logic                       rsp_err,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 35 + TAG_W;
  localparam logic [AW:0] FULL_CNT = DEPTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [15:0]      h_a, h_b;
  logic [2:0]       h_sel;
  logic [TAG_W-1:0] h_tag;
  logic             h_err;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign fifo_level = count;
  assign rsp_valid  = (state == RESP);

  assign {h_a, h_b, h_sel, h_tag} = mem[rd_ptr];
  assign h_err = ((h_sel == 3'b010) || (h_sel == 3'b011)) && (h_b == 16'd0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel, cmd_tag};
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-2 depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (!empty) next_state = ISSUE;
      ISSUE: next_state = err_q ? RESP : WAIT;
      WAIT:  next_state = RESP;
      RESP:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Issue registers; a trapped command leaves the ALU inputs untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_select <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else if (pop) begin
      tag_q <= h_tag;
      err_q <= h_err;
      if (!h_err) begin
        alu_input1 <= h_a;
        alu_input2 <= h_b;
        alu_select <= h_sel;
      end
    end
  end

  // Response capture; held stable while RESP waits for rsp_ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
    end else if (state == ISSUE && err_q) begin
      rsp_data <= 17'h1FFFF;
      rsp_err  <= 1'b1;
      rsp_tag  <= tag_q;
    end else if (state == WAIT) begin
      rsp_data <= alu_out;
      rsp_err  <= 1'b0;
      rsp_tag  <= tag_q;
    end
  end

endmodule
